// File: rtl/psram_stream_sequencer.sv
// Upstream sequencer for a QPI PSRAM controller: buffers 16-bit samples in a FIFO,
// writes them to auto-incrementing addresses and serves single-word host reads.
module psram_stream_sequencer #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter logic [23:0] END_ADDR   = 24'h7FFFFE,
    parameter int          ADDR_STEP  = 2,
    parameter int          TIMEOUT    = 64,
    parameter int          GAP_CYCLES = 2
) (
    input  logic        mem_clk,
    input  logic        rst_n,
    input  logic        psram_ready,
    input  logic        clear,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    input  logic        rd_req,
    input  logic [23:0] rd_addr,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic [23:0] address,
    output logic        read_sw,
    output logic        write_sw,
    output logic [15:0] data_in,
    input  logic        xfer_done,
    input  logic [15:0] data_out,
    output logic [23:0] wr_addr,
    output logic [6:0]  fifo_level,
    output logic        overflow,
    output logic        timeout_err
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, GAP} state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [23:0]   address_q, address_d;
    logic          read_sw_q, read_sw_d;
    logic          write_sw_q, write_sw_d;
    logic [15:0]   data_in_q, data_in_d;
    logic          rd_valid_q, rd_valid_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic [23:0]   wr_addr_q, wr_addr_d;
    logic          overflow_q, overflow_d;
    logic          timeout_err_q, timeout_err_d;
    logic          clr_pend_q, clr_pend_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [6:0]    level_q, level_d;
    logic [15:0]   mem_q [FIFO_DEPTH];

    logic          fifo_full, fifo_empty, push, pop;
    logic [23:0]   wr_addr_next;

    assign fifo_full    = (level_q == 7'(FIFO_DEPTH));
    assign fifo_empty   = (level_q == 7'd0);
    assign s_ready      = !fifo_full;
    assign push         = s_valid && s_ready;
    assign wr_addr_next = (wr_addr_q == END_ADDR) ? BASE_ADDR : wr_addr_q + 24'(ADDR_STEP);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        address_d     = address_q;
        read_sw_d     = read_sw_q;
        write_sw_d    = write_sw_q;
        data_in_d     = data_in_q;
        rd_valid_d    = 1'b0;
        rd_data_d     = rd_data_q;
        wr_addr_d     = wr_addr_q;
        overflow_d    = overflow_q || (s_valid && !s_ready);
        timeout_err_d = timeout_err_q;
        clr_pend_d    = clr_pend_q;
        pop           = 1'b0;

        case (state_q)
            IDLE: begin
                if (psram_ready) begin
                    // A full FIFO outranks a pending read so samples are not lost.
                    if (rd_req && !fifo_full) begin
                        address_d = rd_addr;
                        read_sw_d = 1'b1;
                        cnt_d     = 16'd0;
                        state_d   = READ;
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        address_d  = wr_addr_q;
                        data_in_d  = mem_q[rd_ptr_q];
                        write_sw_d = 1'b1;
                        clr_pend_d = 1'b0;
                        cnt_d      = 16'd0;
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                if (clear) clr_pend_d = 1'b1;
                if (xfer_done) begin
                    write_sw_d = 1'b0;
                    if (!clr_pend_q) wr_addr_d = wr_addr_next;
                    cnt_d      = 16'd0;
                    state_d    = GAP;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    write_sw_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    cnt_d         = 16'd0;
                    state_d       = GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            READ: begin
                if (xfer_done) begin
                    read_sw_d  = 1'b0;
                    rd_valid_d = 1'b1;
                    rd_data_d  = data_out;
                    cnt_d      = 16'd0;
                    state_d    = GAP;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    read_sw_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    cnt_d         = 16'd0;
                    state_d       = GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                if (cnt_q >= 16'(GAP_CYCLES - 1)) begin
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase

        if (clear) begin
            wr_addr_d     = BASE_ADDR;
            overflow_d    = 1'b0;
            timeout_err_d = 1'b0;
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 7'd1;
            2'b01:   level_d = level_q - 7'd1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 16'd0;
            address_q     <= 24'd0;
            read_sw_q     <= 1'b0;
            write_sw_q    <= 1'b0;
            data_in_q     <= 16'd0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= 16'd0;
            wr_addr_q     <= BASE_ADDR;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            clr_pend_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= 7'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            address_q     <= address_d;
            read_sw_q     <= read_sw_d;
            write_sw_q    <= write_sw_d;
            data_in_q     <= data_in_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            wr_addr_q     <= wr_addr_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
            clr_pend_q    <= clr_pend_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge mem_clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    assign address     = address_q;
    assign read_sw     = read_sw_q;
    assign write_sw    = write_sw_q;
    assign data_in     = data_in_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign wr_addr     = wr_addr_q;
    assign fifo_level  = level_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;
endmodule
